// File: rtl/fifo_serial_tx_pkg.sv
// fifo_serial_tx_pkg: state encoding and sizing helpers shared by the serial drain stage
package fifo_serial_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_STOP} state_t;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int FRAME_LEN = (DATA_W_DEF + 2) * CLKS_PER_BIT_DEF;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int frame_len(input int cpb, input int dw);
    return (dw + 2) * cpb;
  endfunction
endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// bit_timer: counts clk cycles within one serial bit
//   clk, clrn   clock, async active-low reset
//   run         count while 1, hold at zero while 0
//   tick        terminal count (last cycle of the bit)
//   pre_tick    one cycle before tick, lets the top register end-of-bit outputs
module bit_timer
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clrn,
  input  logic run,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = run && cnt_q == CW'(CLKS_PER_BIT - 1);
    pre_tick = run && cnt_q == CW'(CLKS_PER_BIT - 2);
    cnt_d = (run && !tick) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops bytes from a FIFO and sends them as start/8N/stop serial frames
//   clk, clrn    clock, async active-low reset
//   fifo_dout    head-of-FIFO byte, fifo_empty FIFO empty flag
//   fifo_read    registered one-cycle pop strobe
//   cts          clear-to-send, sampled only in IDLE
//   txd          serial line (idles high), busy FETCH..STOP, done last STOP cycle
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic              cts,
  output logic              txd,
  output logic              busy,
  output logic              done
);
  localparam int BW = cnt_w(DATA_W);
  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic txd_q, txd_d, fifo_read_q, fifo_read_d, busy_q, busy_d, done_q, done_d;
  logic run, tick, pre_tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .clrn(clrn), .run(run), .tick(tick), .pre_tick(pre_tick)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    run = state_q == S_START || state_q == S_DATA || state_q == S_STOP;
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    case (state_q)
      S_IDLE:  state_d = (!fifo_empty && cts) ? S_FETCH : S_IDLE;
      S_FETCH: begin
        shift_d = fifo_dout;
        bit_d = '0;
        state_d = S_START;
      end
      S_START: state_d = tick ? S_DATA : S_START;
      S_DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = (bit_q == BW'(DATA_W - 1)) ? bit_q : bit_q + 1'b1;
        state_d = (bit_q == BW'(DATA_W - 1)) ? S_STOP : S_DATA;
      end
      S_STOP:  state_d = tick ? S_IDLE : S_STOP;
      default: state_d = S_IDLE;
    endcase
    txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : 1'b1;
    fifo_read_d = state_d == S_FETCH;
    busy_d = state_d != S_IDLE;
    done_d = state_q == S_STOP && pre_tick;
  end

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q <= '0;
      txd_q <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      txd_q <= txd_d;
      fifo_read_q <= fifo_read_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end

  assign txd = txd_q;
  assign fifo_read = fifo_read_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: randomized self-checking bench with a serial receiver model
`timescale 1ns/1ps
module tb_fifo_serial_tx;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 0, clrn = 0, fifo_empty = 1, cts = 0;
  logic [7:0] fifo_dout = 0;
  logic fifo_read, txd, busy, done;
  int errors = 0, checks = 0;
  logic [7:0] fq[$];
  logic [7:0] rx_q[$];
  int bad_q[$], start_q[$], read_q[$];
  int cyc = 0, pops = 0, underflow = 0, double_rd = 0, stray_done = 0;
  int mon_pos = -1, mon_bad = 0;
  logic [7:0] mon_byte = 0;
  logic cell_lvl = 1, prev_rd = 0;

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk(clk), .clrn(clrn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .cts(cts), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pops on a sampled read strobe, head byte is random garbage when empty.
  always @(posedge clk) begin
    if (fifo_read === 1'b1) begin
      pops++;
      if (fq.size() == 0) underflow++;
      else void'(fq.pop_front());
    end
    fifo_empty <= fq.size() == 0;
    fifo_dout <= fq.size() != 0 ? fq[0] : 8'($urandom);
  end

  // Receiver model: finds a start bit, expects 10 level-stable cells of CPB cycles,
  // samples data mid-cell, and expects done only on the last frame cycle.
  always @(negedge clk) begin
    cyc++;
    if (fifo_read === 1'b1) begin
      read_q.push_back(cyc);
      if (prev_rd) double_rd++;
    end
    prev_rd = fifo_read === 1'b1;
    if (!clrn) mon_pos = -1;
    else if (mon_pos < 0 && txd === 1'b0) begin
      mon_pos = 0;
      mon_bad = 0;
      start_q.push_back(cyc);
    end
    if (mon_pos < 0) begin
      if (done === 1'b1) stray_done++;
    end else begin
      if (mon_pos % CPB == 0) cell_lvl = txd;
      else if (txd !== cell_lvl) mon_bad++;
      if (mon_pos < CPB && txd !== 1'b0) mon_bad++;
      if (mon_pos >= FRAME - CPB && txd !== 1'b1) mon_bad++;
      if (mon_pos >= CPB && mon_pos < FRAME - CPB && mon_pos % CPB == CPB / 2)
        mon_byte[3'(mon_pos / CPB - 1)] = txd;
      if (busy !== 1'b1) mon_bad++;
      if (done !== (mon_pos == FRAME - 1)) mon_bad++;
      if (mon_pos == FRAME - 1) begin
        rx_q.push_back(mon_byte);
        bad_q.push_back(mon_bad);
        mon_pos = -1;
      end else mon_pos++;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = rx_q.size() >= n;
    end
  endtask

  task automatic wait_start(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = start_q.size() >= n;
    end
  endtask

  task automatic test_reset();
    int p0 = pops;
    clrn = 0;
    cts = 1;
    fq.push_back(8'he1);
    ticks(6);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", fifo_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pops - p0 != 0) begin errors++; $display("FAIL reset_pops: got %0d want 0", pops - p0); end
    fq.delete();
    cts = 0;
    ticks(2);
    clrn = 1;
    ticks(3);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_release_txd: got %b want 1", txd); end
  endtask

  task automatic test_single();
    int r0 = rx_q.size(), s0 = start_q.size(), d0 = read_q.size(), p0 = pops;
    bit ok;
    fq.push_back(8'he1);
    cts = 1;
    wait_rx(r0 + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames want %0d", rx_q.size() - r0, 1); end
    checks++; if (rx_q[r0] !== 8'he1) begin errors++; $display("FAIL single_byte: got %h want e1", rx_q[r0]); end
    checks++; if (bad_q[r0] != 0) begin errors++; $display("FAIL single_frame_shape: got %0d faults want 0", bad_q[r0]); end
    checks++; if (start_q[s0] - read_q[d0] != 1) begin errors++; $display("FAIL single_fetch_to_start: got %0d want 1", start_q[s0] - read_q[d0]); end
    ticks(5);
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got txd=%b busy=%b want 1 0", txd, busy); end
  endtask

  task automatic test_burst();
    logic [7:0] exp[4] = '{8'he1, 8'he2, 8'he3, 8'he4};
    int r0 = rx_q.size(), s0 = start_q.size(), p0 = pops;
    bit ok;
    cts = 0;
    for (int i = 0; i < 4; i++) fq.push_back(exp[i]);
    ticks(2);
    cts = 1;
    wait_rx(r0 + 4, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d frames want 4", rx_q.size() - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_q[r0 + i] !== exp[i] || bad_q[r0 + i] != 0) begin errors++; $display("FAIL burst_frame%0d: got %h faults=%0d want %h faults=0", i, rx_q[r0 + i], bad_q[r0 + i], exp[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (start_q[s0 + i] - start_q[s0 + i - 1] != FRAME + 2) begin errors++; $display("FAIL burst_gap%0d: got %0d want %0d", i, start_q[s0 + i] - start_q[s0 + i - 1], FRAME + 2); end
    end
    ticks(5);
    checks++; if (pops - p0 != 4) begin errors++; $display("FAIL burst_pops: got %0d want 4", pops - p0); end
    checks++; if (fifo_empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL burst_end_idle: got empty=%b busy=%b want 1 0", fifo_empty, busy); end
  endtask

  task automatic test_flow();
    int r0 = rx_q.size(), s0 = start_q.size(), p0 = pops;
    bit ok;
    cts = 0;
    fq.push_back(8'he1);
    fq.push_back(8'he2);
    ticks(20);
    checks++; if (pops - p0 != 0 || txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flow_blocked: got pops=%0d txd=%b busy=%b want 0 1 0", pops - p0, txd, busy); end
    cts = 1;
    wait_start(s0 + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flow_start_timeout: got %0d starts want 1", start_q.size() - s0); end
    ticks(10);
    cts = 0;
    wait_rx(r0 + 1, 100, ok);
    ticks(60);
    checks++; if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'he1) begin errors++; $display("FAIL flow_first_only: got frames=%0d byte=%h want 1 e1", rx_q.size() - r0, rx_q[r0]); end
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL flow_pops_held: got %0d want 1", pops - p0); end
    cts = 1;
    wait_rx(r0 + 2, 100, ok);
    checks++; if (!ok || rx_q[r0 + 1] !== 8'he2 || bad_q[r0 + 1] != 0) begin errors++; $display("FAIL flow_second: got %h want e2", rx_q[r0 + 1]); end
  endtask

  task automatic test_reset_mid();
    int r0 = rx_q.size(), s0 = start_q.size(), p0 = pops;
    bit ok;
    cts = 1;
    fq.push_back(8'he2);
    fq.push_back(8'he3);
    wait_start(s0 + 1, 20, ok);
    ticks(17);
    clrn = 0;
    #1;
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_immediate: got txd=%b busy=%b want 1 0", txd, busy); end
    checks++; if (fifo_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got read=%b done=%b want 0 0", fifo_read, done); end
    ticks(2);
    clrn = 1;
    wait_rx(r0 + 1, 200, ok);
    checks++; if (!ok || rx_q[r0] !== 8'he3 || bad_q[r0] != 0) begin errors++; $display("FAIL midreset_next: got %h want e3", rx_q[r0]); end
    ticks(60);
    checks++; if (rx_q.size() != r0 + 1 || pops - p0 != 2) begin errors++; $display("FAIL midreset_no_resend: got frames=%0d pops=%0d want 1 2", rx_q.size() - r0, pops - p0); end
  endtask

  task automatic test_empty();
    int p0 = pops, hb = 0;
    cts = 1;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) hb++;
    end
    checks++; if (hb != 0) begin errors++; $display("FAIL empty_line_idle: got %0d bad cycles want 0", hb); end
    checks++; if (pops - p0 != 0) begin errors++; $display("FAIL empty_pops: got %0d want 0", pops - p0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int r0 = rx_q.size(), n = $urandom_range(1, 4);
      logic [7:0] exp[$];
      bit ok;
      cts = 0;
      for (int i = 0; i < n; i++) begin
        exp.push_back(8'($urandom));
        fq.push_back(exp[i]);
      end
      ticks($urandom_range(0, 10));
      cts = 1;
      wait_rx(r0 + n, 60 * n + 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random%0d_timeout: got %0d frames want %0d", r, rx_q.size() - r0, n); end
      for (int i = 0; i < n; i++) begin
        checks++; if (rx_q[r0 + i] !== exp[i] || bad_q[r0 + i] != 0) begin errors++; $display("FAIL random%0d_frame%0d: got %h faults=%0d want %h", r, i, rx_q[r0 + i], bad_q[r0 + i], exp[i]); end
      end
    end
  endtask

  task automatic test_invariants();
    checks++; if (stray_done != 0) begin errors++; $display("FAIL done_outside_frame: got %0d want 0", stray_done); end
    checks++; if (double_rd != 0) begin errors++; $display("FAIL read_longer_than_1: got %0d want 0", double_rd); end
    checks++; if (underflow != 0) begin errors++; $display("FAIL pop_while_empty: got %0d want 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_flow();
    test_reset_mid();
    test_empty();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
